// File: rtl/mag_pkg.sv
// Shared definitions for the magnitude-comparator seek initiator.
package mag_pkg;

  localparam int unsigned MAG_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } seek_state_t;

  // A verdict is legal only when exactly one of gt/eq/lt is set.
  function automatic logic verdict_legal(input logic gt, input logic eq, input logic lt);
    logic [1:0] n;
    n = {1'b0, gt} + {1'b0, eq} + {1'b0, lt};
    return (n == 2'd1);
  endfunction

endpackage

// File: rtl/mag_seek_tmr.sv
// Per-probe wait counter: counts cycles without a verdict, flags the abort cycle.
module mag_seek_tmr
  import mag_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TermCnt = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // tc fires during the TIMEOUT-th consecutive waiting cycle.
  assign tc_o = en_i && !clr_i && (cnt_q == TermCnt);

  // Counter state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mag_seek_16.sv
// MSB-first successive-approximation search driving a magnitude comparator responder.
module mag_seek_16
  import mag_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned W       = MAG_W
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         start,
  output logic [W-1:0] probe,
  output logic         probe_valid,
  input  logic         cmp_valid,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err
);

  localparam int unsigned KW = $clog2(W);

  seek_state_t  state_q;
  logic [W-1:0] acc_q;
  logic [KW-1:0] k_q;
  logic [W-1:0] probe_q, result_q;
  logic         probe_valid_q, busy_q, done_q, found_q, err_q;

  logic [W-1:0] acc_nxt, probe_nxt;
  logic         legal, tmr_en, tmr_clr, tmr_tc;

  // The probe already carries bit k, so an lt verdict keeps it by adopting the probe.
  always_comb begin
    acc_nxt   = cmp_lt ? probe_q : acc_q;
    probe_nxt = acc_nxt | (W'(1) << (k_q - KW'(1)));
    legal     = verdict_legal(cmp_gt, cmp_eq, cmp_lt);
  end

  // Wait counter runs only while a probe is outstanding without a verdict.
  assign tmr_en  = (state_q == PROBE) && !cmp_valid;
  assign tmr_clr = (state_q != PROBE) || cmp_valid;

  mag_seek_tmr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmr (
    .clk_i(sys_clk),
    .rst_i(reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  // Search FSM with all outputs registered.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      k_q           <= '0;
      probe_q       <= '0;
      probe_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      found_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q       <= PROBE;
            acc_q         <= '0;
            k_q           <= KW'(W - 1);
            probe_q       <= {1'b1, {(W - 1){1'b0}}};
            probe_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            result_q      <= '0;
            found_q       <= 1'b0;
            err_q         <= 1'b0;
          end
        end
        PROBE: begin
          if (cmp_valid) begin
            if (!legal) begin
              err_q         <= 1'b1;
              result_q      <= '0;
              state_q       <= DONE;
              probe_valid_q <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
            end else if (cmp_eq) begin
              result_q      <= probe_q;
              found_q       <= 1'b1;
              state_q       <= DONE;
              probe_valid_q <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
            end else if (k_q == '0) begin
              result_q      <= acc_nxt;
              found_q       <= 1'b0;
              state_q       <= DONE;
              probe_valid_q <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
            end else begin
              acc_q   <= acc_nxt;
              k_q     <= k_q - KW'(1);
              probe_q <= probe_nxt;
            end
          end else if (tmr_tc) begin
            err_q         <= 1'b1;
            result_q      <= '0;
            state_q       <= DONE;
            probe_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe       = probe_q;
  assign probe_valid = probe_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign found       = found_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mag_seek_16.sv
// Directed bench for mag_seek_16 with a behavioural comparator responder.
module tb_mag_seek_16;

  localparam int unsigned TO = 8;

  logic        sys_clk = 1'b0;
  logic        reset, start;
  logic [15:0] probe, result;
  logic        probe_valid, busy, done, found, err;
  logic        cmp_valid, cmp_gt, cmp_eq, cmp_lt;

  // Responder configuration.
  logic [15:0] target;
  int          lat;
  bit          rsp_en, rsp_illegal;
  int          lat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] plog [64];
  int          n_probes, done_cyc, hold_bad;

  logic [15:0] exp1234 [14] = '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h1800, 16'h1400,
                                16'h1200, 16'h1300, 16'h1280, 16'h1240, 16'h1220, 16'h1230,
                                16'h1238, 16'h1234};

  always #5 sys_clk = ~sys_clk;

  mag_seek_16 #(
    .TIMEOUT(TO),
    .W      (16)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .start      (start),
    .probe      (probe),
    .probe_valid(probe_valid),
    .cmp_valid  (cmp_valid),
    .cmp_gt     (cmp_gt),
    .cmp_eq     (cmp_eq),
    .cmp_lt     (cmp_lt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .found      (found),
    .err        (err)
  );

  // Comparator responder answering lat cycles after a probe appears.
  always_comb begin
    cmp_valid = probe_valid && rsp_en && (lat_cnt >= lat);
    cmp_gt    = cmp_valid && (rsp_illegal || (probe > target));
    cmp_lt    = cmp_valid && (rsp_illegal || (probe < target));
    cmp_eq    = cmp_valid && !rsp_illegal && (probe == target);
  end

  always @(posedge sys_clk) begin
    if (!probe_valid || cmp_valid) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  // Runs one search; start is re-asserted during cycle start_at (0 = never).
  task automatic run_search(input logic [15:0] tgt, input int l, input bit en, input bit ill,
                            input int start_at);
    int          cyc;
    int          hold;
    logic [15:0] prev;
    bit          prev_pv;
    target = tgt; lat = l; rsp_en = en; rsp_illegal = ill;
    n_probes = 0; done_cyc = 0; hold_bad = 0; hold = 0; prev_pv = 0; prev = '0;
    start = 1'b1;
    @(posedge sys_clk); #1;
    cyc = 1;
    while (cyc <= 200) begin
      start = (cyc == start_at);
      @(negedge sys_clk);
      if (probe_valid) begin
        hold++;
        if (prev_pv && probe !== prev) hold_bad++;
        prev = probe;
      end
      prev_pv = probe_valid;
      if (probe_valid && cmp_valid) begin
        if (n_probes < 64) plog[n_probes] = probe;
        n_probes++;
        if (hold != l + 1) hold_bad++;
        hold = 0;
        prev_pv = 0;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    @(posedge sys_clk); #1;
    start = 1'b0;
    if (done_cyc == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL search_bound got no done within 200 cycles, required done pulse");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rsp_en = 0; rsp_illegal = 0; lat = 0; target = '0;
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b0;
    @(negedge sys_clk);
    n_cmp++; if (probe !== 16'h0) begin n_bad++; $display("FAIL rst_probe got %h want 0000", probe); end
    n_cmp++; if ({probe_valid, busy, done, found, err} !== 5'b0) begin
      n_bad++; $display("FAIL rst_flags got %b want 00000", {probe_valid, busy, done, found, err});
    end
    n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL rst_result got %h want 0000", result); end
  endtask

  task automatic test_target_1234();
    run_search(16'h1234, 0, 1, 0, 0);
    n_cmp++; if (n_probes !== 14) begin n_bad++; $display("FAIL t1234_nprobes got %0d want 14", n_probes); end
    n_cmp++; if (done_cyc !== 15) begin n_bad++; $display("FAIL t1234_donecyc got %0d want 15", done_cyc); end
    n_cmp++; if (result !== 16'h1234) begin n_bad++; $display("FAIL t1234_result got %h want 1234", result); end
    n_cmp++; if ({found, err} !== 2'b10) begin n_bad++; $display("FAIL t1234_found_err got %b want 10", {found, err}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL t1234_idle got %b want 00", {busy, done}); end
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (plog[i] !== exp1234[i]) begin
        n_bad++; $display("FAIL t1234_probe%0d got %h want %h", i, plog[i], exp1234[i]);
      end
    end
  endtask

  task automatic test_target_zero();
    run_search(16'h0000, 0, 1, 0, 0);
    n_cmp++; if (n_probes !== 16) begin n_bad++; $display("FAIL t0_nprobes got %0d want 16", n_probes); end
    n_cmp++; if (done_cyc !== 17) begin n_bad++; $display("FAIL t0_donecyc got %0d want 17", done_cyc); end
    n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL t0_result got %h want 0000", result); end
    n_cmp++; if ({found, err} !== 2'b00) begin n_bad++; $display("FAIL t0_found_err got %b want 00", {found, err}); end
    n_cmp++; if (plog[15] !== 16'h0001) begin n_bad++; $display("FAIL t0_lastprobe got %h want 0001", plog[15]); end
  endtask

  task automatic test_target_ffff();
    run_search(16'hFFFF, 0, 1, 0, 0);
    n_cmp++; if (n_probes !== 16) begin n_bad++; $display("FAIL tf_nprobes got %0d want 16", n_probes); end
    n_cmp++; if (result !== 16'hFFFF) begin n_bad++; $display("FAIL tf_result got %h want ffff", result); end
    n_cmp++; if ({found, err} !== 2'b10) begin n_bad++; $display("FAIL tf_found_err got %b want 10", {found, err}); end
    n_cmp++; if (plog[14] !== 16'hFFFE) begin n_bad++; $display("FAIL tf_probe14 got %h want fffe", plog[14]); end
    n_cmp++; if (plog[15] !== 16'hFFFF) begin n_bad++; $display("FAIL tf_probe15 got %h want ffff", plog[15]); end
  endtask

  // 00A5 needs 16 probes (eight gt above bit 7, then lt/gt/lt/gt/gt/lt/gt/eq), 4 cycles each.
  task automatic test_latency3();
    run_search(16'h00A5, 3, 1, 0, 0);
    n_cmp++; if (n_probes !== 16) begin n_bad++; $display("FAIL lat_nprobes got %0d want 16", n_probes); end
    n_cmp++; if (done_cyc !== 65) begin n_bad++; $display("FAIL lat_donecyc got %0d want 65", done_cyc); end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL lat_hold got %0d bad probes want 0", hold_bad); end
    n_cmp++; if (result !== 16'h00A5) begin n_bad++; $display("FAIL lat_result got %h want 00a5", result); end
    n_cmp++; if ({found, err} !== 2'b10) begin n_bad++; $display("FAIL lat_found_err got %b want 10", {found, err}); end
    n_cmp++; if (plog[9] !== 16'h00C0) begin n_bad++; $display("FAIL lat_probe9 got %h want 00c0", plog[9]); end
  endtask

  task automatic test_timeout();
    run_search(16'h1234, 0, 0, 0, 0);
    n_cmp++; if (done_cyc !== TO + 1) begin n_bad++; $display("FAIL to_donecyc got %0d want %0d", done_cyc, TO + 1); end
    n_cmp++; if (n_probes !== 0) begin n_bad++; $display("FAIL to_nprobes got %0d want 0", n_probes); end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL to_stable got %0d changes want 0", hold_bad); end
    n_cmp++; if ({found, err} !== 2'b01) begin n_bad++; $display("FAIL to_found_err got %b want 01", {found, err}); end
    n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL to_result got %h want 0000", result); end
  endtask

  task automatic test_illegal();
    run_search(16'h1234, 0, 1, 1, 0);
    n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL ill_donecyc got %0d want 2", done_cyc); end
    n_cmp++; if ({found, err} !== 2'b01) begin n_bad++; $display("FAIL ill_found_err got %b want 01", {found, err}); end
    n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL ill_result got %h want 0000", result); end
  endtask

  task automatic test_start_while_busy();
    run_search(16'h1234, 0, 1, 0, 3);
    n_cmp++; if (done_cyc !== 15) begin n_bad++; $display("FAIL busy_donecyc got %0d want 15", done_cyc); end
    n_cmp++; if (n_probes !== 14) begin n_bad++; $display("FAIL busy_nprobes got %0d want 14", n_probes); end
    n_cmp++; if (plog[3] !== 16'h1000) begin n_bad++; $display("FAIL busy_probe3 got %h want 1000", plog[3]); end
    n_cmp++; if (result !== 16'h1234) begin n_bad++; $display("FAIL busy_result got %h want 1234", result); end
  endtask

  // start in the DONE cycle is dropped; a fresh start afterwards works normally.
  task automatic test_back_to_back();
    run_search(16'h0000, 0, 1, 0, 17);
    n_cmp++; if ({busy, probe_valid} !== 2'b00) begin n_bad++; $display("FAIL b2b_ignored got %b want 00", {busy, probe_valid}); end
    @(negedge sys_clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", busy); end
    @(posedge sys_clk); #1;
    run_search(16'hFFFF, 0, 1, 0, 0);
    n_cmp++; if (result !== 16'hFFFF) begin n_bad++; $display("FAIL b2b_result got %h want ffff", result); end
  endtask

  task automatic test_reset_mid_search();
    int dones;
    target = 16'h1234; lat = 0; rsp_en = 1; rsp_illegal = 0;
    start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    n_cmp++; if (probe !== 16'h1800) begin n_bad++; $display("FAIL rm_probe5 got %h want 1800", probe); end
    reset = 1'b1;
    @(posedge sys_clk); #1;
    n_cmp++; if ({probe_valid, busy, done, found, err} !== 5'b0) begin
      n_bad++; $display("FAIL rm_flags got %b want 00000", {probe_valid, busy, done, found, err});
    end
    n_cmp++; if (probe !== 16'h0) begin n_bad++; $display("FAIL rm_probe got %h want 0000", probe); end
    n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL rm_result got %h want 0000", result); end
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rm_nodone got %0d pulses want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_target_1234();
    test_target_zero();
    test_target_ffff();
    test_latency3();
    test_timeout();
    test_illegal();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_search();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want bench end before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
